// File: rtl/fb_plot_engine_if.sv
// -----------------------------------------------------------------------------
// fb_plot_engine_if
//   Command channel into the framebuffer draw engine. The issuing processor
//   holds the master side and the engine holds the slave side. A command is
//   accepted on a rising clock edge where cmd_valid && cmd_ready.
//
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  engine idle and able to accept a command
//   cmd_op     master->slave  00 pixel, 01 rect, 10 clear, 11 read
//   cmd_x0/y0  master->slave  pixel/read coordinate, rect top-left
//   cmd_x1/y1  master->slave  rect bottom-right, inclusive
//   cmd_color  master->slave  draw colour (ignored for read)
// -----------------------------------------------------------------------------
interface fb_plot_engine_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [X_W-1:0]     cmd_x0;
    logic [Y_W-1:0]     cmd_y0;
    logic [X_W-1:0]     cmd_x1;
    logic [Y_W-1:0]     cmd_y1;
    logic [COLOR_W-1:0] cmd_color;

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/fb_plot_engine.sv
// -----------------------------------------------------------------------------
// fb_plot_engine
//   Framebuffer-and-draw engine. Accepts pixel / filled-rect / clear / read
//   commands, rasterises them one pixel per cycle into an internal framebuffer
//   RAM addressed {y,x}, and mirrors every written pixel to the VGA adapter as
//   an x/y/color_out/plot strobe. Pixels outside SCR_W x SCR_H are clipped:
//   they still take their iteration cycle but are neither written nor plotted.
//
//   Optional build macro FB_XOR_MODE_EN: cmd_color MSB becomes an XOR flag;
//   flagged draws take two cycles per pixel (read old, write old ^ colour).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   cmd        command channel (fb_plot_engine_if.slave)
//   x, y       last plotted pixel coordinate (held between plots)
//   color_out  last plotted pixel colour (held between plots)
//   plot       one-cycle strobe per written pixel
//   rd_data    read-back colour, held until the next read
//   rd_valid   one-cycle strobe, rd_data valid
//   busy       command in progress (cycle after accept through done)
//   done       one-cycle strobe at command completion
// -----------------------------------------------------------------------------
module fb_plot_engine #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int SCR_W   = 160,
    parameter int SCR_H   = 120
) (
    input  logic               clk,
    input  logic               reset,
    fb_plot_engine_if.slave    cmd,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color_out,
    output logic               plot,
    output logic [COLOR_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               busy,
    output logic               done
);

    localparam int ADDR_W = X_W + Y_W;

    // One extra bit so SCR_W == 2^X_W (nothing clipped) still compares cleanly.
    localparam logic [X_W:0]   SCR_W_LIM = (X_W + 1)'(SCR_W);
    localparam logic [Y_W:0]   SCR_H_LIM = (Y_W + 1)'(SCR_H);
    localparam logic [X_W-1:0] CLR_X_END = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0] CLR_Y_END = Y_W'(SCR_H - 1);

    typedef enum logic [1:0] {
        OP_PIXEL = 2'b00,
        OP_RECT  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    typedef enum logic [1:0] {IDLE, DRAW, RD_WAIT, DONE} state_t;

    function automatic logic on_screen(input logic [X_W-1:0] px,
                                       input logic [Y_W-1:0] py);
        return ({1'b0, px} < SCR_W_LIM) && ({1'b0, py} < SCR_H_LIM);
    endfunction

    state_t             state;
    logic               cmd_ready_q;
    logic [X_W-1:0]     cur_x, x_start, x_end;
    logic [Y_W-1:0]     cur_y, y_end;
    logic [COLOR_W-1:0] col;
    logic [COLOR_W-1:0] ram_q;
    logic [COLOR_W-1:0] mem [2**ADDR_W];

`ifdef FB_XOR_MODE_EN
    logic               xor_flag;
    logic               phase;      // 0: old pixel being read, 1: write/plot
    logic               acc_xor;
`endif

    // Acceptance decode: iteration bounds for the incoming command.
    logic [X_W-1:0]     acc_sx, acc_ex;
    logic [Y_W-1:0]     acc_sy, acc_ey;
    logic               acc_empty;
    logic [COLOR_W-1:0] acc_col;
    logic               acc_emit;

    // Iterator step and RAM control.
    logic               row_end, last;
    logic [X_W-1:0]     nxt_x;
    logic [Y_W-1:0]     nxt_y;
    logic               cur_on, nxt_on;
    logic               step_en, emit_nxt;
    logic               ram_we;
    logic [COLOR_W-1:0] ram_wdata;
    logic [ADDR_W-1:0]  rd_addr;

    assign cmd.cmd_ready = cmd_ready_q;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        acc_sx    = cmd.cmd_x0;
        acc_sy    = cmd.cmd_y0;
        acc_ex    = cmd.cmd_x0;
        acc_ey    = cmd.cmd_y0;
        acc_empty = 1'b0;
        unique case (op_t'(cmd.cmd_op))
            OP_RECT: begin
                acc_ex    = cmd.cmd_x1;
                acc_ey    = cmd.cmd_y1;
                acc_empty = (cmd.cmd_x1 < cmd.cmd_x0) || (cmd.cmd_y1 < cmd.cmd_y0);
            end
            OP_CLEAR: begin
                acc_sx = '0;
                acc_sy = '0;
                acc_ex = CLR_X_END;
                acc_ey = CLR_Y_END;
            end
            default: ;
        endcase
`ifdef FB_XOR_MODE_EN
        acc_xor  = cmd.cmd_color[COLOR_W-1];
        acc_col  = {1'b0, cmd.cmd_color[COLOR_W-2:0]};
        acc_emit = on_screen(acc_sx, acc_sy) && !acc_xor;
`else
        acc_col  = cmd.cmd_color;
        acc_emit = on_screen(acc_sx, acc_sy);
`endif
    end

    // Row-major walk, x fastest. Termination is an equality compare against
    // the inclusive end, so an end at the maximum code never wraps.
    always_comb begin
        row_end = (cur_x == x_end);
        last    = row_end && (cur_y == y_end);
        nxt_x   = row_end ? x_start : cur_x + 1'b1;
        nxt_y   = row_end ? cur_y + 1'b1 : cur_y;
        cur_on  = on_screen(cur_x, cur_y);
        nxt_on  = on_screen(nxt_x, nxt_y);
        // In IDLE the RAM is addressed straight from the command bus so a
        // read has its data one cycle after acceptance.
        rd_addr = (state == IDLE) ? {cmd.cmd_y0, cmd.cmd_x0} : {cur_y, cur_x};
`ifdef FB_XOR_MODE_EN
        step_en   = !xor_flag || phase;
        emit_nxt  = nxt_on && !xor_flag;
        ram_we    = (state == DRAW) && cur_on && step_en;
        ram_wdata = xor_flag ? (ram_q ^ col) : col;
`else
        step_en   = 1'b1;
        emit_nxt  = nxt_on;
        ram_we    = (state == DRAW) && cur_on;
        ram_wdata = col;
`endif
    end

    // NOTE: the framebuffer has no reset; its contents survive reset and a
    // reset-able RAM would not map onto block memory. Writes are still cut
    // off at once because reset forces state to IDLE, dropping ram_we.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[{cur_y, cur_x}] <= ram_wdata;
        end
        ram_q <= mem[rd_addr];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            plot        <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            x           <= '0;
            y           <= '0;
            color_out   <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            x_start     <= '0;
            x_end       <= '0;
            y_end       <= '0;
            col         <= '0;
`ifdef FB_XOR_MODE_EN
            xor_flag    <= 1'b0;
            phase       <= 1'b0;
`endif
        end else begin
            plot     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd.cmd_valid && cmd_ready_q) begin
                        busy        <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        cur_x       <= acc_sx;
                        cur_y       <= acc_sy;
                        x_start     <= acc_sx;
                        x_end       <= acc_ex;
                        y_end       <= acc_ey;
                        col         <= acc_col;
`ifdef FB_XOR_MODE_EN
                        xor_flag    <= acc_xor;
                        phase       <= 1'b0;
`endif
                        if (op_t'(cmd.cmd_op) == OP_READ) begin
                            state <= RD_WAIT;
                        end else if (acc_empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAW;
                            // The first pixel is presented in the first DRAW
                            // cycle, the same cycle its RAM write completes.
                            if (acc_emit) begin
                                plot      <= 1'b1;
                                x         <= acc_sx;
                                y         <= acc_sy;
                                color_out <= acc_col;
                            end
                        end
                    end
                end
                DRAW: begin
`ifdef FB_XOR_MODE_EN
                    if (xor_flag) begin
                        phase <= ~phase;
                    end
                    // XOR result is only known once the old pixel is back,
                    // so its plot appears the cycle after the write.
                    if (xor_flag && phase && cur_on) begin
                        plot      <= 1'b1;
                        x         <= cur_x;
                        y         <= cur_y;
                        color_out <= ram_wdata;
                    end
`endif
                    if (step_en) begin
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            cur_x <= nxt_x;
                            cur_y <= nxt_y;
                            if (emit_nxt) begin
                                plot      <= 1'b1;
                                x         <= nxt_x;
                                y         <= nxt_y;
                                color_out <= col;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    rd_data  <= cur_on ? ram_q : '0;
                    rd_valid <= 1'b1;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fb_plot_engine.md
Name: fb_plot_engine

Overview:
Parametrised framebuffer-and-draw engine. It is the successor to the fixed 8-bit-coordinate, 3-bit-colour processor/RAM pairing.
- Accepts draw commands over a valid/ready handshake: pixel, filled rectangle, full clear and pixel read-back.
- Rasterises each command into an internal framebuffer RAM.
- Mirrors every written pixel to the VGA adapter as an x/y/color/plot strobe.
- Sits between the command-issuing processor and the VGA adapter.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOR_W, 3, colour width
SCR_W, 160, visible width; pixels with x >= SCR_W are clipped
SCR_H, 120, visible height; pixels with y >= SCR_H are clipped

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_op  in  2  00 pixel, 01 rect, 10 clear, 11 read
cmd_x0  in  X_W  pixel/read x, rect left
cmd_y0  in  Y_W  pixel/read y, rect top
cmd_x1  in  X_W  rect right, inclusive
cmd_y1  in  Y_W  rect bottom, inclusive
cmd_color  in  COLOR_W  draw colour; ignored for read
x  out  X_W  plotted pixel x
y  out  Y_W  plotted pixel y
color_out  out  COLOR_W  plotted pixel colour
plot  out  1  one-cycle strobe per written pixel
rd_data  out  COLOR_W  read-back colour
rd_valid  out  1  one-cycle strobe, rd_data valid
busy  out  1  command in progress
done  out  1  one-cycle strobe at command completion

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 except cmd_ready=1. RAM contents are not cleared.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready is 1 only in IDLE. Command fields are registered at acceptance.
- busy is 1 from the cycle after acceptance through the cycle done pulses.
- RAM: depth 2^(X_W+Y_W), address {y,x}, write port, synchronous read with 1-cycle latency.
- States: IDLE, DRAW, RD_WAIT, DONE.
- Pixel: IDLE -> DRAW, one pixel, -> DONE.
  - Write and plot occur in the cycle after acceptance; x, y and color_out are registered alongside plot.
  - done pulses the following cycle, then the engine returns to IDLE.
- Rect: iterates x0..x1 (x fastest), y0..y1 row-major, one pixel per cycle in DRAW.
  - A W×H rect gives W*H consecutive plot cycles, then done.
  - Empty rect (x1<x0 or y1<y0): zero plots; done pulses 1 cycle after acceptance.
- Clear: identical to a rect (0,0)-(SCR_W-1,SCR_H-1) with cmd_color; SCR_W*SCR_H plots.
- Clipping: a pixel outside the screen still consumes its iteration cycle. It is not written and gets no plot pulse; x/y/color_out hold their previous values.
- Iterator counters are X_W/Y_W wide. An x1 or y1 at its maximum code terminates on an equality compare and must not wrap into an infinite loop.
- Read: IDLE -> RD_WAIT.
  - rd_valid and rd_data appear 2 cycles after acceptance, together with done.
  - Clipped coordinates return rd_data=0. rd_data holds until the next read.
- Read-after-write: a read accepted the cycle after a pixel's done returns the newly written colour.
- Reset mid-command: the command is aborted immediately. Pixels already written remain in RAM, and no done pulse is issued.
- cmd_valid while busy is ignored; the command is not captured.

Optional Feature:
Macro FB_XOR_MODE_EN.
- Defined:
  - cmd_color MSB becomes an XOR flag and the drawn colour is {1'b0, cmd_color[COLOR_W-2:0]}.
  - With the flag set, each pixel takes 2 cycles: read old, then write old^colour. Plot carries the XOR result.
  - A W×H XOR rect takes 2*W*H cycles; plot pulses every other cycle.
- Undefined: full COLOR_W colour, plain overwrite only, no read-before-write logic.

Test Plan:
- Reset released, pixel (5,7) colour 3'b101 -> plot=1 with x=5, y=7, color_out=5 at accept+1; done at accept+2; cmd_ready back to 1.
- Rect (2,3)-(4,4) colour 2 -> 6 consecutive plots (2,3),(3,3),(4,3),(2,4),(3,4),(4,4); done next cycle; read of (3,4) gives rd_data=2 at accept+2.
- Clear colour 1, then reads of (0,0) and (159,119) -> both 1; exactly 19200 plot pulses; pixel (200,10) -> no plot; read of (200,10) -> 0.
- Empty rect (10,10)-(9,12) -> zero plots; done at accept+1. Rect x1=255 with X_W=8 -> terminates; x=160..255 clipped.
- reset driven low mid-clear at plot 50 -> outputs 0 in the same cycle; no done; pixel 49 readable after release with the clear colour, pixel 60 unchanged.
- FB_XOR_MODE_EN: write (1,1) colour 3, XOR-draw (1,1) colour 1 -> plot color_out=2; readback 2; the 2-pixel XOR rect has a plot every other cycle.
